// File: rtl/scan_select_gen.sv
// Select-code sequencer for a downstream 3x8 decoder: sweeps {A,B,C} from 0 to LAST_SEL,
// holding each code TICK_DIV cycles. Optional `SCAN_HOLD_EN adds a hold input that freezes the sweep.
module scan_select_gen #(
    parameter int TICK_DIV = 4,
    parameter int LAST_SEL = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    input  logic mode,
`ifdef SCAN_HOLD_EN
    input  logic hold,
`endif
    output logic A,
    output logic B,
    output logic C,
    output logic En,
    output logic busy,
    output logic done
);

    localparam int TW = $clog2(TICK_DIV) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    SEL_LAST  = 3'(LAST_SEL);

    logic [1:0]    state;
    logic [TW-1:0] tick;
    logic [2:0]    sel;
    logic          mode_q;
    logic          hold_active;

`ifdef SCAN_HOLD_EN
    assign hold_active = hold;
`else
    assign hold_active = 1'b0;
`endif

    assign {A, B, C} = sel;

    // sel, En, busy and done are all flops; every transition sets them for the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tick   <= '0;
            sel    <= 3'd0;
            mode_q <= 1'b0;
            En     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sel  <= 3'd0;
                    En   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    tick <= '0;
                    if (start) begin
                        state  <= ST_RUN;
                        En     <= 1'b1;
                        busy   <= 1'b1;
                        mode_q <= mode;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        sel   <= 3'd0;
                        tick  <= '0;
                        En    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (hold_active) begin
                        tick <= tick;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (sel < SEL_LAST) begin
                            sel <= sel + 3'd1;
                        end else if (mode_q) begin
                            sel <= 3'd0;
                        end else begin
                            state <= ST_DONE;
                            sel   <= 3'd0;
                            En    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    sel   <= 3'd0;
                    tick  <= '0;
                    En    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
